mem_arbiter_rv: RTL and testbench

MEM_ARBITER_RV -- requirements
Module: mem_arbiter_rv

---
 rtl/mem_arbiter_rv_if.sv | 42 ++++
 rtl/mem_arbiter_rv.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter_rv.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_rv_if.sv
// Request/response and memory-side signals of the I/D memory arbiter.
// master: arbiter view; slave: requester/memory environment view.
interface mem_arbiter_rv_if;
  localparam int unsigned XLEN = 32;

  logic            iwIReq;
  logic [XLEN-1:0] iwIAddr;
  logic            owIAck;
  logic [XLEN-1:0] owIRData;

  logic            iwDReq;
  logic [XLEN-1:0] iwDAddr;
  logic            iwDWrite;
  logic [XLEN-1:0] iwDWData;
  logic [1:0]      iwDAccess;
  logic            owDAck;
  logic [XLEN-1:0] owDRData;

  logic            owMemReq;
  logic [XLEN-1:0] owMemAddr;
  logic            owMemWrite;
  logic [XLEN-1:0] owMemWData;
  logic [1:0]      owMemAccess;
  logic            iwMemAck;
  logic [XLEN-1:0] iwMemRData;

  logic            owBusy;

  modport master (
    input  iwIReq, iwIAddr, iwDReq, iwDAddr, iwDWrite, iwDWData, iwDAccess,
    input  iwMemAck, iwMemRData,
    output owIAck, owIRData, owDAck, owDRData,
    output owMemReq, owMemAddr, owMemWrite, owMemWData, owMemAccess, owBusy
  );

  modport slave (
    output iwIReq, iwIAddr, iwDReq, iwDAddr, iwDWrite, iwDWData, iwDAccess,
    output iwMemAck, iwMemRData,
    input  owIAck, owIRData, owDAck, owDRData,
    input  owMemReq, owMemAddr, owMemWrite, owMemWData, owMemAccess, owBusy
  );
endinterface

// File: rtl/mem_arbiter_rv.sv
// Shares one single-ported memory bus between fetch (I) and data (D) requesters.
// Define MEM_ARB_FAIR_EN for alternating fairness; otherwise D has fixed priority over I.
module mem_arbiter_rv (
  input  logic             iwClk,
  input  logic             iwnRst,
  mem_arbiter_rv_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam logic [1:0]  MEM_ACCESS_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic              mem_write_q, mem_write_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_access_q, mem_access_d;
  logic              i_ack_q, i_ack_d;
  logic [XLEN-1:0]   i_rdata_q, i_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              pick_d;
`ifdef MEM_ARB_FAIR_EN
  logic              last_d_q, last_d_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_write_d  = mem_write_q;
    mem_wdata_d  = mem_wdata_q;
    mem_access_d = mem_access_q;
    i_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_ack_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    busy_d       = busy_q;
`ifdef MEM_ARB_FAIR_EN
    last_d_d     = last_d_q;
    pick_d       = bus.iwDReq && (!bus.iwIReq || !last_d_q);
`else
    pick_d       = bus.iwDReq;
`endif

    case (state_q)
      IDLE: begin
        // The cycle showing an Ack is a mandatory gap: no grant, so a
        // requester still holding Req through its Ack is never re-granted.
        if (!(i_ack_q || d_ack_q)) begin
          if (pick_d) begin
            state_d      = D_BUSY;
            mem_req_d    = 1'b1;
            busy_d       = 1'b1;
            mem_addr_d   = bus.iwDAddr;
            mem_write_d  = bus.iwDWrite;
            mem_wdata_d  = bus.iwDWData;
            mem_access_d = bus.iwDAccess;
`ifdef MEM_ARB_FAIR_EN
            last_d_d     = 1'b1;
`endif
          end else if (bus.iwIReq) begin
            state_d      = I_BUSY;
            mem_req_d    = 1'b1;
            busy_d       = 1'b1;
            mem_addr_d   = bus.iwIAddr;
            mem_write_d  = 1'b0;
            mem_wdata_d  = '0;
            mem_access_d = MEM_ACCESS_WORD;
`ifdef MEM_ARB_FAIR_EN
            last_d_d     = 1'b0;
`endif
          end
        end
      end
      I_BUSY: begin
        if (bus.iwMemAck) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          i_ack_d   = 1'b1;
          i_rdata_d = bus.iwMemRData;
        end
      end
      D_BUSY: begin
        if (bus.iwMemAck) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          d_ack_d   = 1'b1;
          d_rdata_d = mem_write_q ? '0 : bus.iwMemRData;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= '0;
      mem_access_q <= '0;
      i_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_ack_q      <= 1'b0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_write_q  <= mem_write_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_access_q <= mem_access_d;
      i_ack_q      <= i_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_ack_q      <= d_ack_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

`ifdef MEM_ARB_FAIR_EN
  // Last grantee: 1 = D; cleared so D wins the first contention
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) last_d_q <= 1'b0;
    else         last_d_q <= last_d_d;
  end
`endif

  assign bus.owMemReq    = mem_req_q;
  assign bus.owMemAddr   = mem_addr_q;
  assign bus.owMemWrite  = mem_write_q;
  assign bus.owMemWData  = mem_wdata_q;
  assign bus.owMemAccess = mem_access_q;
  assign bus.owIAck      = i_ack_q;
  assign bus.owIRData    = i_rdata_q;
  assign bus.owDAck      = d_ack_q;
  assign bus.owDRData    = d_rdata_q;
  assign bus.owBusy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter_rv.sv
// Self-checking bench for mem_arbiter_rv: memory responder model plus
// scoreboard queues of expected memory requests and requester responses.
module tb_mem_arbiter_rv;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [1:0]  access;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   mem_starts = 0;

  txn_t        exp_mem[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  logic [31:0] last_i = 32'h0;
  logic [31:0] last_d = 32'h0;

  logic        mem_auto = 1'b1;
  int          mem_wait = 0;
  int          wait_cnt = 0;
  logic        ack_auto = 1'b0;
  logic [31:0] rdata_auto = 32'h0;
  logic        ack_man = 1'b0;
  logic [31:0] rdata_man = 32'h0;
  logic        mem_prev = 1'b0;

  mem_arbiter_rv_if bus ();

  mem_arbiter_rv dut (
    .iwClk  (clk),
    .iwnRst (rst_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.iwMemAck   = mem_auto ? ack_auto   : ack_man;
  assign bus.iwMemRData = mem_auto ? rdata_auto : rdata_man;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic txn_t mk(input logic [31:0] a, input logic w,
                              input logic [31:0] d, input logic [1:0] acc);
    txn_t t;
    t.addr = a; t.write = w; t.wdata = d; t.access = acc;
    return t;
  endfunction

  // Memory model: acks mem_wait cycles after MemReq is first seen
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_auto = 1'b0;
      wait_cnt = 0;
    end else if (ack_auto) begin
      ack_auto = 1'b0;
    end else if (bus.owMemReq) begin
      if (wait_cnt >= mem_wait) begin
        ack_auto   = 1'b1;
        rdata_auto = mem_word(bus.owMemAddr);
        wait_cnt   = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Scoreboard: pop and compare on each new MemReq and each Ack pulse
  always @(negedge clk) begin
    txn_t obs, t;
    logic [31:0] e;
    if (!rst_n) begin
      mem_prev = 1'b0;
    end else begin
      if (bus.owMemReq && !mem_prev) begin
        mem_starts++;
        n_checks++;
        obs = mk(bus.owMemAddr, bus.owMemWrite, bus.owMemWData, bus.owMemAccess);
        if (exp_mem.size() == 0) begin
          n_errors++;
          $display("FAIL mem_req_unexpected got=%h", obs);
        end else begin
          t = exp_mem.pop_front();
          if (obs !== t) begin
            n_errors++;
            $display("FAIL mem_req_fields got=%h exp=%h", obs, t);
          end
        end
      end
      mem_prev = bus.owMemReq;
      if (bus.owIAck) begin
        n_checks++;
        if (exp_i.size() == 0) begin
          n_errors++;
          $display("FAIL i_ack_unexpected rdata=%h", bus.owIRData);
        end else begin
          e = exp_i.pop_front();
          if (bus.owIRData !== e) begin
            n_errors++;
            $display("FAIL i_rdata got=%h exp=%h", bus.owIRData, e);
          end
        end
      end
      if (bus.owDAck) begin
        n_checks++;
        if (exp_d.size() == 0) begin
          n_errors++;
          $display("FAIL d_ack_unexpected rdata=%h", bus.owDRData);
        end else begin
          e = exp_d.pop_front();
          if (bus.owDRData !== e) begin
            n_errors++;
            $display("FAIL d_rdata got=%h exp=%h", bus.owDRData, e);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_i = 32'h0;
    last_d = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.iwIReq = 1'b1; bus.iwIAddr = 32'h1234;
    bus.iwDReq = 1'b1; bus.iwDAddr = 32'h5678; bus.iwDWrite = 1'b1;
    bus.iwDWData = 32'hFFFF_FFFF; bus.iwDAccess = 2'd2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.owMemReq, bus.owBusy, bus.owIAck, bus.owDAck, bus.owMemWrite, bus.owMemAccess} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl got=%b exp=0", {bus.owMemReq, bus.owBusy, bus.owIAck, bus.owDAck, bus.owMemWrite, bus.owMemAccess});
    end
    n_checks++;
    if ({bus.owMemAddr, bus.owMemWData} !== 64'h0) begin
      n_errors++;
      $display("FAIL reset_mem_bus got=%h exp=0", {bus.owMemAddr, bus.owMemWData});
    end
    n_checks++;
    if ({bus.owIRData, bus.owDRData} !== 64'h0) begin
      n_errors++;
      $display("FAIL reset_rdata got=%h exp=0", {bus.owIRData, bus.owDRData});
    end
    bus.iwIReq = 1'b0; bus.iwDReq = 1'b0; bus.iwDWrite = 1'b0;
    bus.iwDWData = 32'h0; bus.iwIAddr = 32'h0; bus.iwDAddr = 32'h0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.owBusy !== 1'b0 || bus.owMemReq !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle busy=%b req=%b exp=0", bus.owBusy, bus.owMemReq);
    end
  endtask

  task automatic test_single_fetch();
    int cyc = 0;
    logic seen = 1'b0;
    exp_mem.push_back(mk(32'h100, 1'b0, 32'h0, 2'd2));
    exp_i.push_back(32'h0000_0013);
    last_i = 32'h0000_0013;
    bus.iwIReq = 1'b1; bus.iwIAddr = 32'h100;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.owIAck) seen = 1'b1;
    end
    bus.iwIReq = 1'b0;
    n_checks++;
    if (!seen || cyc != 2) begin
      n_errors++;
      $display("FAIL fetch_latency got=%0d seen=%b exp=2", cyc, seen);
    end
    @(negedge clk);
    n_checks++;
    if (bus.owIAck !== 1'b0 || bus.owIRData !== 32'h0000_0013 || bus.owBusy !== 1'b0) begin
      n_errors++;
      $display("FAIL fetch_after ack=%b rdata=%h busy=%b exp 0/00000013/0", bus.owIAck, bus.owIRData, bus.owBusy);
    end
  endtask

  task automatic test_store();
    int req_cycles = 0;
    logic seen = 1'b0;
    mem_wait = 3;
    exp_mem.push_back(mk(32'h2004, 1'b1, 32'hDEAD_BEEF, 2'd0));
    exp_d.push_back(32'h0);
    last_d = 32'h0;
    bus.iwDReq = 1'b1; bus.iwDWrite = 1'b1; bus.iwDAddr = 32'h2004;
    bus.iwDWData = 32'hDEAD_BEEF; bus.iwDAccess = 2'd0;
    @(negedge clk);
    // Requester changes mid-transaction must not reach the memory side
    bus.iwDReq = 1'b0; bus.iwDWrite = 1'b0; bus.iwDAddr = 32'hFFFF_FFF0;
    bus.iwDWData = 32'h0; bus.iwDAccess = 2'd2;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.owMemReq) begin
        req_cycles++;
        n_checks++;
        if ({bus.owMemAddr, bus.owMemWrite, bus.owMemWData, bus.owMemAccess} !==
            {32'h2004, 1'b1, 32'hDEAD_BEEF, 2'd0}) begin
          n_errors++;
          $display("FAIL store_stable got=%h/%b/%h/%0d", bus.owMemAddr, bus.owMemWrite, bus.owMemWData, bus.owMemAccess);
        end
      end
      if (bus.owDAck) seen = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!seen || req_cycles != 4) begin
      n_errors++;
      $display("FAIL store_req_cycles got=%0d seen=%b exp=4", req_cycles, seen);
    end
    @(negedge clk);
    n_checks++;
    if (bus.owDAck !== 1'b0 || bus.owDRData !== 32'h0) begin
      n_errors++;
      $display("FAIL store_after ack=%b rdata=%h exp 0/0", bus.owDAck, bus.owDRData);
    end
    mem_wait = 0;
  endtask

  task automatic test_ack_guard();
    int starts0 = mem_starts;
    logic seen = 1'b0;
    exp_mem.push_back(mk(32'h300, 1'b0, 32'h0, 2'd2));
    exp_i.push_back(mem_word(32'h300));
    last_i = mem_word(32'h300);
    bus.iwIReq = 1'b1; bus.iwIAddr = 32'h300;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.owIAck) seen = 1'b1;
    end
    @(negedge clk);
    bus.iwIReq = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (!seen || mem_starts - starts0 != 1) begin
      n_errors++;
      $display("FAIL guard_txn_count got=%0d seen=%b exp=1", mem_starts - starts0, seen);
    end
    n_checks++;
    if (bus.owBusy !== 1'b0 || exp_i.size() != 0) begin
      n_errors++;
      $display("FAIL guard_idle busy=%b pending=%0d exp 0/0", bus.owBusy, exp_i.size());
    end
  endtask

  task automatic test_contention();
    int acks = 0;
    logic d_turn;
    do_reset();
    for (int n = 0; n < 6; n++) begin
`ifdef MEM_ARB_FAIR_EN
      d_turn = (n % 2) == 0;
`else
      d_turn = 1'b1;
`endif
      if (d_turn) begin
        exp_mem.push_back(mk(32'h400, 1'b0, 32'h1111_2222, 2'd1));
        exp_d.push_back(mem_word(32'h400));
        last_d = mem_word(32'h400);
      end else begin
        exp_mem.push_back(mk(32'h600, 1'b0, 32'h0, 2'd2));
        exp_i.push_back(mem_word(32'h600));
        last_i = mem_word(32'h600);
      end
    end
    bus.iwIReq = 1'b1; bus.iwIAddr = 32'h600;
    bus.iwDReq = 1'b1; bus.iwDAddr = 32'h400; bus.iwDWrite = 1'b0;
    bus.iwDWData = 32'h1111_2222; bus.iwDAccess = 2'd1;
    for (int k = 0; k < 100 && acks < 6; k++) begin
      @(negedge clk);
      if (bus.owIAck || bus.owDAck) acks++;
    end
    bus.iwIReq = 1'b0; bus.iwDReq = 1'b0;
    n_checks++;
    if (acks != 6) begin
      n_errors++;
      $display("FAIL contention_acks got=%0d exp=6", acks);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_mem.size() + exp_i.size() + exp_d.size() != 0 || bus.owBusy !== 1'b0) begin
      n_errors++;
      $display("FAIL contention_drain pending=%0d busy=%b exp 0/0", exp_mem.size() + exp_i.size() + exp_d.size(), bus.owBusy);
    end
  endtask

  task automatic test_spurious_ack();
    mem_auto = 1'b0;
    ack_man = 1'b1; rdata_man = 32'hBAD0_BAD0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.owIAck, bus.owDAck, bus.owBusy, bus.owMemReq} !== 4'b0) begin
        n_errors++;
        $display("FAIL spurious_idle got=%b exp=0000", {bus.owIAck, bus.owDAck, bus.owBusy, bus.owMemReq});
      end
    end
    ack_man = 1'b0;
    mem_auto = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.owIRData !== last_i || bus.owDRData !== last_d) begin
      n_errors++;
      $display("FAIL rdata_hold got=%h/%h exp=%h/%h", bus.owIRData, bus.owDRData, last_i, last_d);
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    int cyc = 0;
    mem_auto = 1'b0; ack_man = 1'b0;
    exp_mem.push_back(mk(32'h500, 1'b0, 32'h0, 2'd2));
    bus.iwDReq = 1'b1; bus.iwDWrite = 1'b0; bus.iwDAddr = 32'h500;
    bus.iwDWData = 32'h0; bus.iwDAccess = 2'd2;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.owMemReq) seen = 1'b1;
    end
    bus.iwDReq = 1'b0;
    @(negedge clk);
    ack_man = 1'b1; rdata_man = 32'h7777_7777;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.owMemReq, bus.owBusy, bus.owDAck, bus.owMemAddr, bus.owDRData} !== 67'h0 || !seen) begin
      n_errors++;
      $display("FAIL reset_mid_outputs req=%b busy=%b dack=%b addr=%h seen=%b exp all 0", bus.owMemReq, bus.owBusy, bus.owDAck, bus.owMemAddr, seen);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_man = 1'b0;
    last_i = 32'h0; last_d = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.owDAck !== 1'b0 || bus.owBusy !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_mid_no_ack dack=%b busy=%b exp 0/0", bus.owDAck, bus.owBusy);
      end
    end
    mem_auto = 1'b1;
    seen = 1'b0;
    exp_mem.push_back(mk(32'h700, 1'b0, 32'h0, 2'd2));
    exp_i.push_back(mem_word(32'h700));
    last_i = mem_word(32'h700);
    bus.iwIReq = 1'b1; bus.iwIAddr = 32'h700;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.owIAck) seen = 1'b1;
    end
    bus.iwIReq = 1'b0;
    n_checks++;
    if (!seen || cyc != 2) begin
      n_errors++;
      $display("FAIL post_reset_fetch latency=%0d seen=%b exp=2", cyc, seen);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.iwIReq = 1'b0; bus.iwIAddr = 32'h0;
    bus.iwDReq = 1'b0; bus.iwDAddr = 32'h0; bus.iwDWrite = 1'b0;
    bus.iwDWData = 32'h0; bus.iwDAccess = 2'd0;
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_store();
    test_ack_guard();
    test_contention();
    test_spurious_ack();
    test_reset_mid();
    n_checks++;
    if (exp_mem.size() + exp_i.size() + exp_d.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_mem.size() + exp_i.size() + exp_d.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end
endmodule
